execute_unit: RTL and testbench
===============================

Name: execute_unit

Overview:
- Execute stage directly downstream of operand fetch. Consumes op1, op2, immx, branchTarget, pc and the 6-bit opcodeI ({opcode[4:0], I}).
- Produces the ALU/address result, the persistent compare flags, and the branch decision and target for fetch.
- Single-cycle ops complete in one cycle. mul/div/mod use an iterative 32-step datapath with an in_valid/in_ready handshake toward operand fetch.

Parameters:
- W, 32, datapath width; only 32 is supported.
- ITER, 32, iterations for mul/div/mod; equal to W.

Ports:
- clk  input  1  stage clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand fetch presents a valid instruction
- in_ready  output  1  execute can accept this cycle
- flush  input  1  synchronous kill of the in-flight or accepting instruction
- opcodeI  input  6  [5:1] opcode, [0] immediate select I
- op1  input  32  operand A / return address for ret
- op2  input  32  operand B register value
- immx  input  32  sign-extended immediate
- branchTarget  input  32  pc + offset from operand fetch
- pc  input  32  pc of the presented instruction
- out_valid  output  1  one-cycle pulse; result fields are valid
- out_result  output  32  ALU result / memory address / return address
- out_flag_e  output  1  flags.E
- out_flag_gt  output  1  flags.GT
- out_branch_taken  output  1  branch redirect, qualified by out_valid
- out_branch_pc  output  32  redirect target

Behaviour:
- Operand B = opcodeI[0] ? immx : op2. Operand A = op1.
- Reset: state IDLE; in_ready=1; out_valid=0; out_result=0; flags E=GT=0; out_branch_taken=0; out_branch_pc=0. Any in-flight mul/div/mod is aborted.
- Accept occurs at an edge where in_valid & in_ready & !flush.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0; iteration counter 31..0.
- Single-cycle ops: accepted at edge T, outputs registered at T; out_valid=1 for the cycle after T only.
- Opcode map:
  - add 00000, sub 00001: A+B, A-B, modulo 2^32.
  - cmp 00101: E=(A==B), GT=(signed A > signed B); out_result=0.
  - and 00110, or 00111: bitwise A&B, A|B.
  - not 01000: ~B.
  - mov 01001: B.
  - lsl 01010, lsr 01011, asr 01100: shift A by B[4:0].
  - nop 01101 and reserved 10101-11111: result 0, no branch.
  - ld 01110, st 01111: out_result = A+immx, regardless of I.
- Flags change only on an accepted cmp and hold until the next cmp or reset.
- Branches:
  - beq 10000 taken iff E; bgt 10001 taken iff GT, using flags as they stand before this instruction.
  - b 10010 and call 10011 always taken; out_branch_pc=branchTarget.
  - call: out_result = pc+4.
  - ret 10100: taken, out_branch_pc=op1.
  - Not-taken: out_branch_taken=0, out_branch_pc=0.
- mul 00010, div 00011, mod 00100:
  - Accept at edge T latches the operands and enters BUSY.
  - One step per edge, T+1..T+32. The step at T+32 registers the result and returns to IDLE.
  - out_valid high during cycle T+33. in_ready is low for cycles T+1..T+32 and high in cycle T+33, so back-to-back accept is allowed.
  - mul: low 32 bits of the shift-add product; identical result for signed or unsigned.
  - div/mod: signed; magnitudes go through unsigned restoring division, then sign fix-up. Quotient is truncated toward zero; remainder takes the dividend's sign.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - 0x80000000 / -1: quotient 0x80000000, remainder 0.
- Flush:
  - In IDLE: nothing is accepted.
  - In BUSY: return to IDLE at that edge with no out_valid. This includes the completion edge T+32, whose result is suppressed.
  - Flags are never altered by flush.
- rst has priority over flush; flush has priority over accept.
- out_* hold their last values when out_valid=0, except out_valid itself.

Test Plan:
- Reset, then add with op1=5, op2=7, I=0 -> out_valid one cycle later, out_result=12.
- cmp with A=3, B=3, then beq with branchTarget=0x40 -> E=1, GT=0, out_branch_taken=1, out_branch_pc=0x40. Then cmp with A=-1, B=2, then bgt -> GT=0, branch not taken.
- mul 0xFFFFFFFF x 3, accepted at cycle 10 -> in_ready low for cycles 11-42, out_valid in cycle 43, out_result=0xFFFFFFFD.
- div -7/2 -> -3 (0xFFFFFFFD); mod -7,2 -> -1; div 9/0 -> 0xFFFFFFFF; mod 9,0 -> 9; div 0x80000000/-1 -> 0x80000000.
- flush asserted at the 20th BUSY cycle of a div -> no out_valid, in_ready=1 the next cycle, flags unchanged. A following add issues normally.
- rst asserted mid-mul, then call with pc=0x100, branchTarget=0x200 -> outputs at reset values; after reset, out_result=0x104, out_branch_pc=0x200, taken=1.

Source files
------------

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU/branch ops plus a 32-step iterative mul/div/mod
// datapath, with persistent compare flags and a valid/ready handshake toward fetch.
module execute_unit #(
   parameter int W    = 32,
   parameter int ITER = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         flush,
   input  logic [5:0]   opcodeI,
   input  logic [W-1:0] op1,
   input  logic [W-1:0] op2,
   input  logic [W-1:0] immx,
   input  logic [W-1:0] branchTarget,
   input  logic [W-1:0] pc,
   output logic         out_valid,
   output logic [W-1:0] out_result,
   output logic         out_flag_e,
   output logic         out_flag_gt,
   output logic         out_branch_taken,
   output logic [W-1:0] out_branch_pc
);

   localparam int CW = $clog2(ITER);

   localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010,
                          OP_DIV = 5'b00011, OP_MOD = 5'b00100, OP_CMP = 5'b00101,
                          OP_AND = 5'b00110, OP_OR  = 5'b00111, OP_NOT = 5'b01000,
                          OP_MOV = 5'b01001, OP_LSL = 5'b01010, OP_LSR = 5'b01011,
                          OP_ASR = 5'b01100, OP_LD  = 5'b01110, OP_ST  = 5'b01111,
                          OP_BEQ = 5'b10000, OP_BGT = 5'b10001, OP_B   = 5'b10010,
                          OP_CAL = 5'b10011, OP_RET = 5'b10100;

   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_n;

   logic [4:0]   op;
   logic [W-1:0] a, b;
   logic         accept, is_long, done;

   assign op       = opcodeI[5:1];
   assign a        = op1;
   assign b        = opcodeI[0] ? immx : op2;
   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready & ~flush;
   assign is_long  = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);

   // iterative datapath registers: x = multiplicand / dividend->quotient shifter,
   // y = multiplier / divisor magnitude, acc = product / partial remainder
   logic [4:0]    lop;
   logic [W-1:0]  x_r, y_r, acc_r;
   logic [CW-1:0] cnt;
   logic          neg_q, neg_r, dz;

   assign done = (state == BUSY) && (cnt == '0);

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (accept && is_long) state_n = BUSY;
         BUSY: if (flush || done)     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // single-cycle result and branch decision
   logic [W-1:0] res_c, bpc_c;
   logic         tk_c;

   always_comb begin
      res_c = '0;
      tk_c  = 1'b0;
      bpc_c = '0;
      case (op)
         OP_ADD: res_c = a + b;
         OP_SUB: res_c = a - b;
         OP_AND: res_c = a & b;
         OP_OR:  res_c = a | b;
         OP_NOT: res_c = ~b;
         OP_MOV: res_c = b;
         OP_LSL: res_c = a << b[4:0];
         OP_LSR: res_c = a >> b[4:0];
         OP_ASR: res_c = W'($signed(a) >>> b[4:0]);
         OP_LD, OP_ST: res_c = a + immx;
         OP_BEQ: begin tk_c = out_flag_e;  bpc_c = out_flag_e  ? branchTarget : '0; end
         OP_BGT: begin tk_c = out_flag_gt; bpc_c = out_flag_gt ? branchTarget : '0; end
         OP_B:   begin tk_c = 1'b1; bpc_c = branchTarget; end
         OP_CAL: begin tk_c = 1'b1; bpc_c = branchTarget; res_c = pc + W'(4); end
         OP_RET: begin tk_c = 1'b1; bpc_c = op1; end
         default: ;
      endcase
   end

   // one iteration step, shared by mul (shift-add) and div/mod (restoring)
   logic [W-1:0] x_n, y_n, acc_n, fin;
   logic [W:0]   r_sh, diff;

   always_comb begin
      x_n   = x_r;
      y_n   = y_r;
      acc_n = acc_r;
      r_sh  = {acc_r, x_r[W-1]};
      diff  = r_sh - {1'b0, y_r};
      if (lop == OP_MUL) begin
         acc_n = acc_r + (y_r[0] ? x_r : '0);
         x_n   = x_r << 1;
         y_n   = y_r >> 1;
      end else if (!diff[W]) begin
         acc_n = diff[W-1:0];
         x_n   = {x_r[W-2:0], 1'b1};
      end else begin
         acc_n = r_sh[W-1:0];
         x_n   = {x_r[W-2:0], 1'b0};
      end
      case (lop)
         OP_MUL:  fin = acc_n;
         OP_DIV:  fin = dz ? '1 : (neg_q ? -x_n : x_n);
         default: fin = neg_r ? -acc_n : acc_n;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         out_valid        <= 1'b0;
         out_result       <= '0;
         out_flag_e       <= 1'b0;
         out_flag_gt      <= 1'b0;
         out_branch_taken <= 1'b0;
         out_branch_pc    <= '0;
         lop              <= '0;
         x_r              <= '0;
         y_r              <= '0;
         acc_r            <= '0;
         cnt              <= '0;
         neg_q            <= 1'b0;
         neg_r            <= 1'b0;
         dz               <= 1'b0;
      end else begin
         state     <= state_n;
         out_valid <= 1'b0;
         if (state == IDLE && accept) begin
            if (is_long) begin
               lop   <= op;
               x_r   <= (op == OP_MUL || !a[W-1]) ? a : -a;
               y_r   <= (op == OP_MUL || !b[W-1]) ? b : -b;
               acc_r <= '0;
               cnt   <= CW'(ITER - 1);
               neg_q <= a[W-1] ^ b[W-1];
               neg_r <= a[W-1];
               dz    <= (b == '0);
            end else begin
               out_valid        <= 1'b1;
               out_result       <= res_c;
               out_branch_taken <= tk_c;
               out_branch_pc    <= bpc_c;
               if (op == OP_CMP) begin
                  out_flag_e  <= (a == b);
                  out_flag_gt <= ($signed(a) > $signed(b));
               end
            end
         end else if (state == BUSY && !flush) begin
            x_r   <= x_n;
            y_r   <= y_n;
            acc_r <= acc_n;
            cnt   <= cnt - 1'b1;
            if (done) begin
               out_valid        <= 1'b1;
               out_result       <= fin;
               out_branch_taken <= 1'b0;
               out_branch_pc    <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: ALU, flags, branches, iterative mul/div/mod,
// flush and reset behaviour, with hand-computed expectations.
module tb_execute_unit;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush;
   logic [5:0]  opcodeI;
   logic [31:0] op1, op2, immx, branchTarget, pc;
   logic        out_valid, out_flag_e, out_flag_gt, out_branch_taken;
   logic [31:0] out_result, out_branch_pc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   execute_unit #(.W(32), .ITER(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .opcodeI(opcodeI), .op1(op1), .op2(op2), .immx(immx),
      .branchTarget(branchTarget), .pc(pc), .out_valid(out_valid),
      .out_result(out_result), .out_flag_e(out_flag_e), .out_flag_gt(out_flag_gt),
      .out_branch_taken(out_branch_taken), .out_branch_pc(out_branch_pc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // present one instruction for a single edge; returns #1 after that edge
   task automatic issue(input logic [4:0] op, input logic i, input logic [31:0] a,
                        input logic [31:0] bb, input logic [31:0] im,
                        input logic [31:0] bt, input logic [31:0] p);
      opcodeI = {op, i}; op1 = a; op2 = bb; immx = im; branchTarget = bt; pc = p;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // after a long-op accept: busy for 32 cycles, then a one-cycle result
   task automatic long_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] bb, input logic [31:0] exp);
      int busy_bad = 0;
      issue(op, 1'b0, a, bb, 32'h0, 32'h0, 32'h0);
      for (int k = 1; k <= 32; k++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
         @(posedge clk); #1;
      end
      chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
      chk({tag, "_valid"}, {30'd0, out_valid, in_ready}, 32'd3);
      chk({tag, "_res"}, out_result, exp);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; opcodeI = '0;
      op1 = '0; op2 = '0; immx = '0; branchTarget = '0; pc = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_res", out_result, 32'd0);
      chk("rst_flags", {30'd0, out_flag_e, out_flag_gt}, 32'd0);
      chk("rst_br", {31'd0, out_branch_taken}, 32'd0);
      chk("rst_bpc", out_branch_pc, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      issue(5'b00000, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0);
      chk("add_valid", {31'd0, out_valid}, 32'd1);
      chk("add_res", out_result, 32'd12);
      @(posedge clk); #1;
      chk("pulse_once", {31'd0, out_valid}, 32'd0);
      chk("hold_res", out_result, 32'd12);

      issue(5'b00001, 1'b1, 32'd10, 32'd99, 32'd3, 32'd0, 32'd0);
      chk("subi_res", out_result, 32'd7);
      issue(5'b01100, 1'b0, 32'h8000_0000, 32'd36, 32'd0, 32'd0, 32'd0);
      chk("asr_res", out_result, 32'hF800_0000);
      issue(5'b01110, 1'b0, 32'h100, 32'd55, 32'd8, 32'd0, 32'd0);
      chk("ld_res", out_result, 32'h108);
      issue(5'b01000, 1'b1, 32'd0, 32'd0, 32'h0000_00FF, 32'd0, 32'd0);
      chk("not_res", out_result, 32'hFFFF_FF00);

      issue(5'b00101, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 32'd0);
      chk("cmp_eq_flags", {30'd0, out_flag_e, out_flag_gt}, 32'd2);
      chk("cmp_res", out_result, 32'd0);
      issue(5'b10000, 1'b0, 32'd0, 32'd0, 32'd0, 32'h40, 32'd0);
      chk("beq_taken", {31'd0, out_branch_taken}, 32'd1);
      chk("beq_pc", out_branch_pc, 32'h40);
      issue(5'b00101, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0);
      chk("cmp_neg_flags", {30'd0, out_flag_e, out_flag_gt}, 32'd0);
      issue(5'b10001, 1'b0, 32'd0, 32'd0, 32'd0, 32'h80, 32'd0);
      chk("bgt_taken", {31'd0, out_branch_taken}, 32'd0);
      chk("bgt_pc", out_branch_pc, 32'd0);
      issue(5'b10100, 1'b0, 32'h1234, 32'd0, 32'd0, 32'h80, 32'd0);
      chk("ret_pc", out_branch_pc, 32'h1234);

      long_op("mul", 5'b00010, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
      long_op("div_neg", 5'b00011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      long_op("mod_neg", 5'b00100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      long_op("div_zero", 5'b00011, 32'd9, 32'd0, 32'hFFFF_FFFF);
      long_op("mod_zero", 5'b00100, 32'd9, 32'd0, 32'd9);
      long_op("div_ovf", 5'b00011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      long_op("mod_ovf", 5'b00100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

      // set GT so a flush can be shown not to disturb it
      issue(5'b00101, 1'b0, 32'd5, 32'd2, 32'd0, 32'd0, 32'd0);
      issue(5'b00011, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 32'd0);
      repeat (19) begin @(posedge clk); #1; end
      chk("fl_busy", {31'd0, in_ready}, 32'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_ready", {31'd0, in_ready}, 32'd1);
      chk("fl_flags", {30'd0, out_flag_e, out_flag_gt}, 32'd1);
      repeat (16) begin @(posedge clk); #1; end
      chk("fl_quiet", {31'd0, out_valid}, 32'd0);
      issue(5'b00000, 1'b1, 32'd20, 32'd0, 32'd22, 32'd0, 32'd0);
      chk("fl_add", out_result, 32'd42);

      issue(5'b00010, 1'b0, 32'd6, 32'd7, 32'd0, 32'd0, 32'd0);
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mrst_ready", {31'd0, in_ready}, 32'd1);
      chk("mrst_res", out_result, 32'd0);
      chk("mrst_flags", {30'd0, out_flag_e, out_flag_gt}, 32'd0);
      issue(5'b10011, 1'b0, 32'd0, 32'd0, 32'd0, 32'h200, 32'h100);
      chk("call_res", out_result, 32'h104);
      chk("call_pc", out_branch_pc, 32'h200);
      chk("call_taken", {31'd0, out_branch_taken}, 32'd1);
      repeat (40) begin @(posedge clk); #1; end
      chk("mrst_no_late", {31'd0, out_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
